fir_decimator: RTL and testbench

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator.sv | 141 ++++++++++++++
 tb/tb_fir_decimator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// Decimating accumulator behind a FIR filter: sums DECIM samples, rounds, shifts and queues results in a small FIFO.
// Define FIR_DECIMATOR_SAT_EN to saturate results to OUT_WIDTH; otherwise results wrap to their low OUT_WIDTH bits.
module fir_decimator #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        drop
);

  localparam int PW  = $clog2(DECIM);
  localparam int AW  = IN_WIDTH + PW;
  localparam int RW  = AW + 1;
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int CW  = FPW + 1;
  localparam logic [PW-1:0]        LAST_PHASE = PW'(DECIM - 1);
  localparam logic [CW-1:0]        DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic signed [RW-1:0] RND_C      = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);

  // Narrow the shifted result to the output width (saturating or wrapping).
  function automatic logic signed [OUT_WIDTH-1:0] reduce(input logic signed [RW-1:0] v);
    logic signed [OUT_WIDTH-1:0] r;
`ifdef FIR_DECIMATOR_SAT_EN
    if (!v[RW-1] && (|v[RW-2:OUT_WIDTH-1])) begin
      r = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (v[RW-1] && !(&v[RW-2:OUT_WIDTH-1])) begin
      r = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      r = v[OUT_WIDTH-1:0];
    end
`else
    r = v[OUT_WIDTH-1:0];
`endif
    return r;
  endfunction

  logic [PW-1:0]               phase_r;
  logic signed [AW-1:0]        acc_r;
  logic signed [AW-1:0]        sum_r;
  logic                        dump_r;
  logic signed [AW-1:0]        in_ext_s;
  logic signed [RW-1:0]        rnd_s;
  logic signed [RW-1:0]        shifted_s;
  logic signed [OUT_WIDTH-1:0] res_s;

  logic signed [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [FPW-1:0]              wptr_r;
  logic [FPW-1:0]              rptr_r;
  logic [CW-1:0]               count_r;
  logic                        pop_s;
  logic                        full_s;
  logic                        push_s;
  logic                        bypass_s;
  logic [CW-1:0]               count_nxt_s;
  logic [FPW-1:0]              rptr_nxt_s;

  assign in_ext_s  = AW'(in_data);
  assign rnd_s     = RW'(sum_r) + RND_C;
  assign shifted_s = rnd_s >>> SHIFT;
  assign res_s     = reduce(shifted_s);

  assign pop_s       = out_valid && out_ready;
  assign full_s      = (count_r == DEPTH_C);
  assign push_s      = dump_r && (!full_s || pop_s);
  assign count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
  assign rptr_nxt_s  = rptr_r + FPW'(pop_s);
  // A push into a FIFO that is empty after this edge's pop becomes the new head directly.
  assign bypass_s    = push_s && ((count_r - CW'(pop_s)) == '0);

  // Phase counter, accumulator and dump register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= '0;
      acc_r   <= '0;
      sum_r   <= '0;
      dump_r  <= 1'b0;
    end else begin
      dump_r <= 1'b0;
      if (in_valid) begin
        if (phase_r == LAST_PHASE) begin
          sum_r   <= acc_r + in_ext_s;
          acc_r   <= '0;
          phase_r <= '0;
          dump_r  <= 1'b1;
        end else begin
          acc_r   <= acc_r + in_ext_s;
          phase_r <= phase_r + PW'(1);
        end
      end else begin
        acc_r   <= acc_r;
        phase_r <= phase_r;
      end
    end
  end

  // FIFO storage; data entries need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= res_s;
    end
  end

  // FIFO pointers, registered head, valid and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      count_r   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      drop      <= 1'b0;
    end else begin
      wptr_r    <= push_s ? wptr_r + FPW'(1) : wptr_r;
      rptr_r    <= rptr_nxt_s;
      count_r   <= count_nxt_s;
      out_valid <= (count_nxt_s != '0);
      if (bypass_s) begin
        out_data <= res_s;
      end else if (count_nxt_s != '0) begin
        out_data <= mem_r[rptr_nxt_s];
      end else begin
        out_data <= out_data;
      end
      if (dump_r && full_s && !pop_s) begin
        drop <= 1'b1;
      end else begin
        drop <= drop;
      end
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed testbench for fir_decimator at default parameters (DECIM=4, SHIFT=2, FIFO_DEPTH=4).
module tb_fir_decimator;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [15:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              drop;
  int                n_tests = 0;
  int                n_fail  = 0;

`ifdef FIR_DECIMATOR_SAT_EN
  localparam logic signed [7:0] SAT_EXP = 8'sd127;
`else
  localparam logic signed [7:0] SAT_EXP = -8'sd24;
`endif

  fir_decimator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send(input logic signed [15:0] v);
    in_valid = 1'b1; in_data = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b1; in_data = 16'sd77; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 8'sd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop); end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send(16'sd1); send(16'sd2); send(16'sd3); send(16'sd4);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got valid %b expected 0", out_valid); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== 8'sd3) begin n_fail++; $display("FAIL basic_data: got %0d expected 3", out_data); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_negative;
    apply_reset();
    out_ready = 1'b1;
    send(-16'sd1); send(-16'sd1); send(-16'sd1); send(-16'sd2);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL neg_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== -8'sd1) begin n_fail++; $display("FAIL neg_data: got %0d expected -1", out_data); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_saturate;
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(16'sd1000);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== SAT_EXP) begin n_fail++; $display("FAIL sat_data: got %0d expected %0d", out_data, SAT_EXP); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_fifo_full;
    int pops;
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) send(16'sd4);
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL full_drop_early: got %b expected 0", drop); end
    @(negedge clk);
    n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %b expected 1", drop); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b expected 1", out_valid); end
    @(negedge clk);
    n_tests++; if (out_data !== 8'sd4) begin n_fail++; $display("FAIL full_hold: got %0d expected 4", out_data); end
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) begin
        pops++;
        n_tests++; if (out_data !== 8'sd4) begin n_fail++; $display("FAIL full_drain_data: got %0d expected 4", out_data); end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_tests++; if (pops != 4) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 4", pops); end
    n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL full_drop_sticky: got %b expected 1", drop); end
  endtask

  task automatic test_back_to_back;
    int pops;
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) send(16'sd4);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== 8'sd4) begin n_fail++; $display("FAIL b2b_head: got %0d expected 4", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b expected 0", drop); end
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) pops++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_tests++; if (pops + 1 != 5) begin n_fail++; $display("FAIL b2b_total: got %0d expected 5", pops + 1); end
  endtask

  task automatic test_one_entry;
    apply_reset();
    out_ready = 1'b0;
    send(16'sd1); send(16'sd2); send(16'sd3); send(16'sd4);
    for (int k = 0; k < 4; k++) send(16'sd4);
    n_tests++; if (out_data !== 8'sd3) begin n_fail++; $display("FAIL one_first: got %0d expected 3", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL one_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== 8'sd4) begin n_fail++; $display("FAIL one_second: got %0d expected 4", out_data); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL one_empty: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int outs;
    apply_reset();
    out_ready = 1'b1;
    send(16'sd100); send(16'sd100);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) send(16'sd4);
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) begin
        outs++;
        n_tests++; if (out_data !== 8'sd4) begin n_fail++; $display("FAIL mid_data: got %0d expected 4", out_data); end
      end
      @(negedge clk);
    end
    n_tests++; if (outs != 1) begin n_fail++; $display("FAIL mid_count: got %0d expected 1", outs); end
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL mid_drop: got %b expected 0", drop); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_fifo_full();
    test_back_to_back();
    test_one_entry();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
